// File: rtl/vga_sync_decoder.sv
// Sync-line monitor: recovers DrawX/DrawY, frame_start and lock from hs/vs sampled on Clk.
// Define VGA_SYNC_DECODER_BLANK_CHECK_EN to build the blank-versus-coordinate checker.
module vga_sync_decoder #(
    parameter int H_TOTAL      = 800,
    parameter int H_SYNC_START = 656,
    parameter int V_TOTAL      = 525,
    parameter int V_SYNC_START = 490,
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       VGA_clk,
    input  logic       hs,
    input  logic       vs,
    input  logic       blank,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       pix_valid,
    output logic       frame_start,
    output logic       locked,
    output logic       sync_err,
    output logic       blank_err
);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_LOAD = 10'(H_SYNC_START);
    localparam logic [9:0] V_LOAD = 10'(V_SYNC_START);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    state_t     state_q, state_d;
    logic       vclk_p0, vclk_p1, vclk_p2, vld_p2;
    logic       hs_p0, hs_p1, hs_p2;
    logic       vs_p0, vs_p1, vs_p2;
    logic       hs_prev, vs_prev;
    logic [9:0] hcnt, vcnt;
    logic [9:0] hcnt_adv, vcnt_adv, hcnt_nxt, vcnt_nxt;
    logic       h_wrap, hs_fall, vs_fall, hs_bad, vs_bad;
    logic       meas_ok, meas_ok_d, set_sync_err;

    // Stages p0/p1: two-flop synchronizers; p2: pixel-strobe detect with aligned sync samples
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            vclk_p0 <= 1'b0;
            vclk_p1 <= 1'b0;
            vclk_p2 <= 1'b0;
            vld_p2  <= 1'b0;
            hs_p0   <= 1'b0;
            hs_p1   <= 1'b0;
            hs_p2   <= 1'b0;
            vs_p0   <= 1'b0;
            vs_p1   <= 1'b0;
            vs_p2   <= 1'b0;
        end else begin
            vclk_p0 <= VGA_clk;
            vclk_p1 <= vclk_p0;
            vclk_p2 <= vclk_p1;
            vld_p2  <= vclk_p1 & ~vclk_p2;
            hs_p0   <= hs;
            hs_p1   <= hs_p0;
            hs_p2   <= hs_p1;
            vs_p0   <= vs;
            vs_p1   <= vs_p0;
            vs_p2   <= vs_p1;
        end
    end

    // Stage p3: counter advance, sync-edge loads and edge qualification
    always_comb begin
        hs_fall  = vld_p2 & hs_prev & ~hs_p2;
        vs_fall  = vld_p2 & vs_prev & ~vs_p2;
        hcnt_adv = (hcnt == H_LAST) ? 10'd0 : hcnt + 10'd1;
        h_wrap   = (hcnt == H_LAST) & ~hs_fall;
        if (h_wrap) begin
            vcnt_adv = (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
        end else begin
            vcnt_adv = vcnt;
        end
        hcnt_nxt = hs_fall ? H_LOAD : hcnt_adv;
        vcnt_nxt = vs_fall ? V_LOAD : vcnt_adv;
        // An edge is expected when plain counting would already land on the load value
        hs_bad   = hs_fall & (hcnt_adv != H_LOAD);
        vs_bad   = vs_fall & (vcnt_adv != V_LOAD);
    end

    always_comb begin
        state_d      = state_q;
        meas_ok_d    = meas_ok;
        set_sync_err = 1'b0;
        case (state_q)
            SEARCH: begin
                if (vs_fall) begin
                    state_d   = MEASURE;
                    meas_ok_d = 1'b1;
                end
            end
            MEASURE: begin
                if (hs_bad) begin
                    meas_ok_d = 1'b0;
                end
                if (vs_fall) begin
                    state_d = (meas_ok && !hs_bad && !vs_bad) ? LOCKED : SEARCH;
                end
            end
            LOCKED: begin
                if (hs_bad || vs_bad) begin
                    state_d      = SEARCH;
                    set_sync_err = 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= SEARCH;
            meas_ok     <= 1'b0;
            hcnt        <= 10'd0;
            vcnt        <= 10'd0;
            hs_prev     <= 1'b0;
            vs_prev     <= 1'b0;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state_q     <= state_d;
            meas_ok     <= meas_ok_d;
            pix_valid   <= vld_p2;
            frame_start <= vld_p2 && (state_q == LOCKED) &&
                           (hcnt_nxt == 10'd0) && (vcnt_nxt == 10'd0);
            if (set_sync_err) begin
                sync_err <= 1'b1;
            end
            if (vld_p2) begin
                hcnt    <= hcnt_nxt;
                vcnt    <= vcnt_nxt;
                hs_prev <= hs_p2;
                vs_prev <= vs_p2;
            end
        end
    end

    assign DrawX  = hcnt;
    assign DrawY  = vcnt;
    assign locked = (state_q == LOCKED);

`ifdef VGA_SYNC_DECODER_BLANK_CHECK_EN
    logic blank_p0, blank_p1, blank_p2, blank_exp;

    // Stages p0..p2: blank follows the same delay as hs/vs so it lines up with the strobe
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            blank_p0 <= 1'b0;
            blank_p1 <= 1'b0;
            blank_p2 <= 1'b0;
        end else begin
            blank_p0 <= blank;
            blank_p1 <= blank_p0;
            blank_p2 <= blank_p1;
        end
    end

    // Stage p3: blank (active low) must be high exactly inside the visible window
    assign blank_exp = (hcnt_nxt < 10'(H_ACTIVE)) && (vcnt_nxt < 10'(V_ACTIVE));

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            blank_err <= 1'b0;
        end else if (vld_p2 && (state_q == LOCKED) && (blank_p2 != blank_exp)) begin
            blank_err <= 1'b1;
        end
    end
`else
    logic unused_blank;
    assign unused_blank = blank;
    assign blank_err    = 1'b0;
`endif

endmodule
